// File: rtl/mux4x1_rr_arbiter_if.sv
// Request/grant bundle between the four requesters and the shared 4:1 mux arbiter.
interface mux4x1_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       S0;
  logic       S1;
  logic       busy;
  logic       preempt;

  modport master (
    output req,
    input  gnt, S0, S1, busy, preempt
  );

  modport slave (
    input  req,
    output gnt, S0, S1, busy, preempt
  );
endinterface

// File: rtl/mux4x1_rr_arbiter.sv
// Round-robin owner selection for one shared 4:1 mux, with a hold limit that forces
// rotation whenever another requester is waiting. All outputs are registered.
module mux4x1_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mux4x1_rr_arbiter_if.slave     bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_own;
  logic [7:0] r_cnt;
  logic [3:0] r_gnt;
  logic       r_busy;
  logic       r_preempt;

  logic [3:0] w_own_oh;
  logic [3:0] w_others;
  logic [1:0] w_win_all;
  logic [1:0] w_win_oth;
  logic       w_at_limit;
  logic       w_take;
  logic [1:0] w_win;
  logic       w_pre;
  logic       w_idle;

  // First asserted candidate starting at ptr and wrapping mod 4; callers
  // only use the result when cand is non-zero.
  function automatic logic [1:0] rr_pick(input logic [3:0] cand, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (cand[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  assign w_own_oh   = onehot(r_own);
  assign w_others   = bus.req & ~w_own_oh;
  assign w_win_all  = rr_pick(bus.req, r_ptr);
  assign w_win_oth  = rr_pick(w_others, r_ptr);
  assign w_at_limit = (r_cnt >= HOLD_LIM);

  // Arbitration decision for this edge: new grant, drop to idle, or keep owner.
  always_comb begin
    w_take = 1'b0;
    w_win  = w_win_all;
    w_pre  = 1'b0;
    w_idle = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_take = |bus.req;
      end
      GRANT: begin
        if (!bus.req[r_own]) begin
          if (|w_others) begin
            w_take = 1'b1;
            w_win  = w_win_oth;
          end else begin
            w_idle = 1'b1;
          end
        end else if (w_at_limit && (|w_others)) begin
          w_take = 1'b1;
          w_win  = w_win_oth;
          w_pre  = 1'b1;
        end
      end
      default: begin
        w_idle = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= 2'd0;
      r_own     <= 2'd0;
      r_cnt     <= 8'd0;
      r_gnt     <= 4'b0000;
      r_busy    <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      if (w_take) begin
        r_state   <= GRANT;
        r_own     <= w_win;
        r_ptr     <= w_win + 2'd1;
        r_cnt     <= 8'd1;
        r_gnt     <= onehot(w_win);
        r_busy    <= 1'b1;
        r_preempt <= w_pre;
      end else if (w_idle) begin
        // Owner index is kept so the mux select holds its last value.
        r_state <= IDLE;
        r_cnt   <= 8'd0;
        r_gnt   <= 4'b0000;
        r_busy  <= 1'b0;
      end else if (r_state == GRANT) begin
        // Lone owner at the limit restarts its count instead of rotating.
        r_cnt <= w_at_limit ? 8'd1 : (r_cnt + 8'd1);
      end
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.S0      = r_own[0];
  assign bus.S1      = r_own[1];
  assign bus.busy    = r_busy;
  assign bus.preempt = r_preempt;

endmodule

// File: tb/tb_mux4x1_rr_arbiter.sv
// Directed bench for mux4x1_rr_arbiter: four instances with different hold limits,
// expected outputs queued as each step is driven and checked after the edge.
module tb_mux4x1_rr_arbiter;

  logic clk;
  logic rst_n;

  mux4x1_rr_arbiter_if if_a ();
  mux4x1_rr_arbiter_if if_b ();
  mux4x1_rr_arbiter_if if_c ();
  mux4x1_rr_arbiter_if if_d ();

  mux4x1_rr_arbiter #(.MAX_HOLD(8)) u_mh8 (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  mux4x1_rr_arbiter #(.MAX_HOLD(4)) u_mh4 (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  mux4x1_rr_arbiter #(.MAX_HOLD(2)) u_mh2 (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));
  mux4x1_rr_arbiter #(.MAX_HOLD(1)) u_mh1 (.clk(clk), .rst_n(rst_n), .bus(if_d.slave));

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       pre;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] sample(input int id);
    logic [7:0] v;
    case (id)
      0:       v = {if_a.gnt, if_a.S1, if_a.S0, if_a.busy, if_a.preempt};
      1:       v = {if_b.gnt, if_b.S1, if_b.S0, if_b.busy, if_b.preempt};
      2:       v = {if_c.gnt, if_c.S1, if_c.S0, if_c.busy, if_c.preempt};
      default: v = {if_d.gnt, if_d.S1, if_d.S0, if_d.busy, if_d.preempt};
    endcase
    return v;
  endfunction

  task automatic drive(input int id, input logic [3:0] rq);
    case (id)
      0:       if_a.req = rq;
      1:       if_b.req = rq;
      2:       if_c.req = rq;
      default: if_d.req = rq;
    endcase
  endtask

  task automatic push_exp(input logic [3:0] eg, input logic [1:0] es, input logic ep);
    exp_t e;
    e.gnt  = eg;
    e.sel  = es;
    e.busy = |eg;
    e.pre  = ep;
    sb.push_back(e);
  endtask

  task automatic compare(input int id, input string tag);
    exp_t       e;
    logic [7:0] obs;
    e   = sb.pop_front();
    obs = sample(id);
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s dut%0d gnt/S1S0/busy/preempt observed=%b_%b_%b_%b expected=%b_%b_%b_%b",
             tag, id, obs[7:4], obs[3:2], obs[1], obs[0], e.gnt, e.sel, e.busy, e.pre);
    end
  endtask

  // Drive req, clock one edge, check the registered outputs 1 time unit later.
  task automatic step(input int id, input logic [3:0] rq, input logic [3:0] eg,
                      input logic [1:0] es, input logic ep, input string tag);
    push_exp(eg, es, ep);
    drive(id, rq);
    @(posedge clk);
    #1;
    compare(id, tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) drive(i, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) drive(i, 4'b0000);

    // Reset held, then idle with no requests
    for (int i = 0; i < 3; i++) step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, "reset_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, "idle_noreq");

    // Single requester 2, dropped at edge 6; select holds 10 afterwards
    step(0, 4'b0100, 4'b0100, 2'd2, 1'b0, "single_grant");
    for (int i = 0; i < 4; i++) step(0, 4'b0100, 4'b0100, 2'd2, 1'b0, "single_hold");
    step(0, 4'b0000, 4'b0000, 2'd2, 1'b0, "single_release");
    step(0, 4'b0000, 4'b0000, 2'd2, 1'b0, "single_sel_hold");

    // Fairness: each owner keeps 2 cycles, drops for one, re-raises
    do_reset();
    step(0, 4'b1111, 4'b0001, 2'd0, 1'b0, "fair_g0");
    step(0, 4'b1111, 4'b0001, 2'd0, 1'b0, "fair_g0_hold");
    step(0, 4'b1110, 4'b0010, 2'd1, 1'b0, "fair_g1");
    step(0, 4'b1111, 4'b0010, 2'd1, 1'b0, "fair_g1_hold");
    step(0, 4'b1101, 4'b0100, 2'd2, 1'b0, "fair_g2");
    step(0, 4'b1111, 4'b0100, 2'd2, 1'b0, "fair_g2_hold");
    step(0, 4'b1011, 4'b1000, 2'd3, 1'b0, "fair_g3");
    step(0, 4'b1111, 4'b1000, 2'd3, 1'b0, "fair_g3_hold");
    step(0, 4'b0111, 4'b0001, 2'd0, 1'b0, "fair_wrap_g0");

    // Forced rotation with MAX_HOLD=4
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 4'b0011, 4'b0001, 2'd0, 1'b0, "rot_own0");
    step(1, 4'b0011, 4'b0010, 2'd1, 1'b1, "rot_pre_to1");
    for (int i = 0; i < 3; i++) step(1, 4'b0011, 4'b0010, 2'd1, 1'b0, "rot_own1");
    step(1, 4'b0011, 4'b0001, 2'd0, 1'b1, "rot_pre_to0");
    step(1, 4'b0011, 4'b0001, 2'd0, 1'b0, "rot_own0_again");

    // Lone hog with MAX_HOLD=2
    do_reset();
    for (int i = 0; i < 10; i++) step(2, 4'b1000, 4'b1000, 2'd3, 1'b0, "hog_keep");

    // MAX_HOLD=1 with all requesting: rotate every cycle
    do_reset();
    step(3, 4'b1111, 4'b0001, 2'd0, 1'b0, "mh1_first");
    step(3, 4'b1111, 4'b0010, 2'd1, 1'b1, "mh1_r1");
    step(3, 4'b1111, 4'b0100, 2'd2, 1'b1, "mh1_r2");
    step(3, 4'b1111, 4'b1000, 2'd3, 1'b1, "mh1_r3");
    step(3, 4'b1111, 4'b0001, 2'd0, 1'b1, "mh1_r0");
    step(3, 4'b1111, 4'b0010, 2'd1, 1'b1, "mh1_r1b");

    // Asynchronous reset in the middle of a grant
    do_reset();
    step(0, 4'b0010, 4'b0010, 2'd1, 1'b0, "async_pre_grant");
    #2;
    rst_n = 1'b0;
    #1;
    push_exp(4'b0000, 2'd0, 1'b0);
    compare(0, "async_reset_clear");
    drive(0, 4'b1111);
    @(posedge clk);
    #1;
    push_exp(4'b0000, 2'd0, 1'b0);
    compare(0, "async_reset_held");
    #2;
    rst_n = 1'b1;
    step(0, 4'b1111, 4'b0001, 2'd0, 1'b0, "post_reset_ptr0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
